// File: rtl/sfu_pkg.sv
// Shared definitions for the psum sequencer: FSM state encoding and SFU command bit positions.
// No logic; imported by psum_seq.
// Counter width is shared so every counter and tag bus stays 11 bits.
package sfu_pkg;
    localparam int CNT_W = 11;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_WRITE = 3'd1;
    localparam logic [2:0] ST_ACC   = 3'd2;
    localparam logic [2:0] ST_READ  = 3'd3;
    localparam logic [2:0] ST_DRAIN = 3'd4;

    localparam int SFU_WR  = 0;
    localparam int SFU_ACC = 1;
    localparam int SFU_RD  = 2;
endpackage

// File: rtl/tag_delay.sv
// Fixed-depth shift pipe that carries a valid flag plus tags alongside the SFU read path.
// Latency: DEPTH cycles from d to q.
// Backpressure: none; flush clears every stage synchronously.
module tag_delay #(
    parameter int W     = 23,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         flush,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    logic [W-1:0] pipe [DEPTH];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) pipe[i] <= '0;
        end else if (flush) begin
            for (int i = 0; i < DEPTH; i++) pipe[i] <= '0;
        end else begin
            pipe[0] <= d;
            for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
        end
    end

    assign q = pipe[DEPTH-1];
endmodule

// File: rtl/psum_seq.sv
// Tile sequencer: streams psum words into the SFU, triggers accumulate, then reads results back out.
// Latency: read results appear RD_LAT cycles after each issue; done coincides with the final out_valid.
// Backpressure: psum_ready is high only in WRITE; every other phase runs on fixed cycle counts.
module psum_seq
    import sfu_pkg::*;
#(
    parameter int LEN_NIJ = 16,
    parameter int LEN_KIJ = 9,
    parameter int NUM_OC  = 8,
    parameter int RD_LAT  = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic             psum_valid,
    output logic             psum_ready,
    output logic [3:0]       sfu_inst,
    output logic [CNT_W-1:0] sfu_nij,
    output logic [CNT_W-1:0] sfu_oc,
    output logic             out_valid,
    output logic [CNT_W-1:0] out_nij,
    output logic [CNT_W-1:0] out_oc,
    output logic             busy,
    output logic             done
);
    localparam logic [CNT_W-1:0] WR_LAST  = CNT_W'(LEN_KIJ * LEN_NIJ - 1);
    // ACC spans the accumulate cycle plus the full wait, so its terminal is the wait length itself
    localparam logic [CNT_W-1:0] ACC_LAST = CNT_W'((LEN_KIJ + 1) * LEN_NIJ);
    localparam logic [CNT_W-1:0] NIJ_LAST = CNT_W'(LEN_NIJ - 1);
    localparam logic [CNT_W-1:0] OC_LAST  = CNT_W'(NUM_OC - 1);
    localparam logic [CNT_W-1:0] DR_LAST  = CNT_W'(RD_LAT - 1);

    logic [2:0]       state;
    logic [CNT_W-1:0] wcnt, acnt, rd_nij, rd_oc, dcnt;
    logic             accept, rd_issue;
    logic [2*CNT_W:0] dly_q;

    assign psum_ready = (state == ST_WRITE);
    assign accept     = psum_valid & psum_ready;
    assign rd_issue   = (state == ST_READ);
    assign busy       = (state != ST_IDLE);
    assign done       = (state == ST_DRAIN) && (dcnt == DR_LAST) && !abort;
    assign sfu_nij    = rd_nij;
    assign sfu_oc     = rd_oc;

    always_comb begin
        sfu_inst = 4'b0000;
        if (accept)                             sfu_inst[SFU_WR]  = 1'b1;
        if ((state == ST_ACC) && (acnt == '0))  sfu_inst[SFU_ACC] = 1'b1;
        if (rd_issue)                           sfu_inst[SFU_RD]  = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= ST_IDLE;
            wcnt   <= '0;
            acnt   <= '0;
            rd_nij <= '0;
            rd_oc  <= '0;
            dcnt   <= '0;
        end else if (abort) begin
            state  <= ST_IDLE;
            wcnt   <= '0;
            acnt   <= '0;
            rd_nij <= '0;
            rd_oc  <= '0;
            dcnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state <= ST_WRITE;
                        wcnt  <= '0;
                    end
                end
                ST_WRITE: begin
                    if (accept) begin
                        if (wcnt == WR_LAST) begin
                            state <= ST_ACC;
                            wcnt  <= '0;
                            acnt  <= '0;
                        end else begin
                            wcnt <= wcnt + 1'b1;
                        end
                    end
                end
                ST_ACC: begin
                    if (acnt == ACC_LAST) begin
                        state  <= ST_READ;
                        acnt   <= '0;
                        rd_nij <= '0;
                        rd_oc  <= '0;
                    end else begin
                        acnt <= acnt + 1'b1;
                    end
                end
                ST_READ: begin
                    if (rd_oc == OC_LAST) begin
                        rd_oc <= '0;
                        if (rd_nij == NIJ_LAST) begin
                            state  <= ST_DRAIN;
                            rd_nij <= '0;
                            dcnt   <= '0;
                        end else begin
                            rd_nij <= rd_nij + 1'b1;
                        end
                    end else begin
                        rd_oc <= rd_oc + 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (dcnt == DR_LAST) begin
                        state <= ST_IDLE;
                        dcnt  <= '0;
                    end else begin
                        dcnt <= dcnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    tag_delay #(
        .W     (2 * CNT_W + 1),
        .DEPTH (RD_LAT)
    ) u_tag_delay (
        .clk   (clk),
        .reset (reset),
        .flush (abort),
        .d     ({rd_issue, rd_nij, rd_oc}),
        .q     (dly_q)
    );

    assign out_valid = dly_q[2*CNT_W];
    assign out_nij   = dly_q[2*CNT_W-1:CNT_W];
    assign out_oc    = dly_q[CNT_W-1:0];
endmodule

// File: tb/tb_psum_seq.sv
// Directed bench for psum_seq: scenario table run against a cycle schedule, plus reset/abort corner sequences.
module tb_psum_seq;
    localparam int WRITES = 144;
    localparam int WAIT   = 160;
    localparam int READS  = 128;
    localparam int NOC    = 8;
    localparam int LAT    = 2;

    logic        clk = 1'b0;
    logic        reset, start, abort, psum_valid;
    logic        psum_ready, out_valid, busy, done;
    logic [3:0]  sfu_inst;
    logic [10:0] sfu_nij, sfu_oc, out_nij, out_oc;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    psum_seq dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .abort      (abort),
        .psum_valid (psum_valid),
        .psum_ready (psum_ready),
        .sfu_inst   (sfu_inst),
        .sfu_nij    (sfu_nij),
        .sfu_oc     (sfu_oc),
        .out_valid  (out_valid),
        .out_nij    (out_nij),
        .out_oc     (out_oc),
        .busy       (busy),
        .done       (done)
    );

    typedef struct {
        string name;
        bit    rnd;
        int    restart_at;
        int    abort_at;
        int    exp_writes;
        int    exp_dones;
    } scen_t;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Layout: ready, inst[3:0], busy, done, out_valid, out_nij, out_oc, sfu_nij, sfu_oc
    function automatic logic [51:0] pack(input logic rdy, input logic [3:0] inst, input logic bsy,
                                         input logic dn, input logic ov, input logic [10:0] onij,
                                         input logic [10:0] ooc, input logic [10:0] snij,
                                         input logic [10:0] soc);
        return {rdy, inst, bsy, dn, ov, onij, ooc, snij, soc};
    endfunction

    function automatic logic [51:0] exp_vec(input int i, input int wend, input bit v, input int ab);
        int rs;
        int k;
        rs = wend + 2 + WAIT;
        if (ab >= 0 && i > ab)
            return '0;
        if (i <= wend)
            return pack(1'b1, {3'b000, v}, 1'b1, 1'b0, 1'b0, 11'd0, 11'd0, 11'd0, 11'd0);
        if (i == wend + 1)
            return pack(1'b0, 4'b0010, 1'b1, 1'b0, 1'b0, 11'd0, 11'd0, 11'd0, 11'd0);
        if (i < rs)
            return pack(1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 11'd0, 11'd0, 11'd0, 11'd0);
        if (i < rs + READS) begin
            k = i - rs;
            if (k >= LAT)
                return pack(1'b0, 4'b0100, 1'b1, 1'b0, 1'b1, 11'((k - LAT) / NOC), 11'((k - LAT) % NOC),
                            11'(k / NOC), 11'(k % NOC));
            return pack(1'b0, 4'b0100, 1'b1, 1'b0, 1'b0, 11'd0, 11'd0, 11'(k / NOC), 11'(k % NOC));
        end
        if (i < rs + READS + LAT) begin
            k = i - rs - LAT;
            return pack(1'b0, 4'b0000, 1'b1, (i == rs + READS + LAT - 1), 1'b1,
                        11'(k / NOC), 11'(k % NOC), 11'd0, 11'd0);
        end
        return '0;
    endfunction

    task automatic run_tile(input scen_t s);
        bit          vpat [1024];
        int          ones, wend, last, writes, dones;
        logic [51:0] e, a;
        ones = 0;
        wend = -1;
        writes = 0;
        dones = 0;
        for (int i = 0; i < 1024; i++) begin
            vpat[i] = (s.rnd && i < 400) ? 1'($urandom_range(0, 1)) : 1'b1;
            if (vpat[i] && wend < 0) begin
                ones++;
                if (ones == WRITES) wend = i;
            end
        end
        last = (s.abort_at >= 0) ? s.abort_at + 4 : wend + 2 + WAIT + READS + LAT + 2;
        @(negedge clk);
        start = 1'b1;
        for (int i = 0; i <= last; i++) begin
            @(negedge clk);
            start      = (i == s.restart_at);
            abort      = (i == s.abort_at);
            psum_valid = vpat[i];
            #1;
            e = exp_vec(i, wend, vpat[i], s.abort_at);
            a = pack(psum_ready, sfu_inst, busy, done, out_valid,
                     e[44] ? out_nij : 11'd0, e[44] ? out_oc : 11'd0,
                     (e[50:47] == 4'b0100) ? sfu_nij : 11'd0,
                     (e[50:47] == 4'b0100) ? sfu_oc : 11'd0);
            chk($sformatf("%s_cyc%0d", s.name, i), {12'd0, a}, {12'd0, e});
            if (sfu_inst == 4'b0001) writes++;
            if (done) dones++;
        end
        start      = 1'b0;
        abort      = 1'b0;
        psum_valid = 1'b0;
        chk({s.name, "_writes"}, 64'(writes), 64'(s.exp_writes));
        chk({s.name, "_dones"}, 64'(dones), 64'(s.exp_dones));
    endtask

    scen_t tbl [8];

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tbl[0] = '{"held",          1'b0,  -1,  -1, 144, 1};
        tbl[1] = '{"rand50",        1'b1,  -1,  -1, 144, 1};
        tbl[2] = '{"restart_acc",   1'b0, 200,  -1, 144, 1};
        tbl[3] = '{"restart_write", 1'b0,  50,  -1, 144, 1};
        tbl[4] = '{"restart_read",  1'b0, 340,  -1, 144, 1};
        tbl[5] = '{"abort_w70",     1'b0,  -1,  69,  70, 0};
        tbl[6] = '{"after_abort",   1'b0,  -1,  -1, 144, 1};
        tbl[7] = '{"abort_read",    1'b0,  -1, 310, 144, 0};

        reset = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        psum_valid = 1'b0;
        #1;
        chk("reset_state", {12'd0, pack(psum_ready, sfu_inst, busy, done, out_valid, out_nij, out_oc,
                                        sfu_nij, sfu_oc)}, 64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        #1;
        chk("idle_after_reset", {60'd0, psum_ready, busy, done, out_valid}, 64'd0);

        // start and abort together in IDLE: abort wins
        @(negedge clk);
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        #1;
        chk("start_abort_busy", {63'd0, busy}, 64'd0);
        chk("start_abort_inst", {59'd0, psum_ready, sfu_inst}, 64'd0);

        for (int t = 0; t < 8; t++) run_tile(tbl[t]);

        // asynchronous reset in the middle of the read phase
        @(negedge clk);
        start = 1'b1;
        psum_valid = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (320) @(negedge clk);
        #2;
        chk("pre_reset_read", {59'd0, busy, sfu_inst}, {59'd0, 1'b1, 4'b0100});
        reset = 1'b1;
        #1;
        chk("async_reset_outputs", {12'd0, pack(psum_ready, sfu_inst, busy, done, out_valid, out_nij,
                                                out_oc, sfu_nij, sfu_oc)}, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        psum_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            chk($sformatf("post_reset_quiet%0d", i), {61'd0, out_valid, busy, done}, 64'd0);
        end
        run_tile('{"after_reset", 1'b0, -1, -1, 144, 1});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/psum_seq.md
PSUM_SEQ -- requirements
Module: psum_seq

Interface
REQ-001 Parameter LEN_NIJ, default 16: output pixels per tile.
REQ-002 Parameter LEN_KIJ, default 9: kernel positions per tile.
REQ-003 Parameter NUM_OC, default 8: 16-bit output-channel lanes per psum word.
REQ-004 Parameter RD_LAT, default 2: SFU read latency in cycles, from read issue to valid data.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 start  input  1  pulse that begins a tile; ignored unless the block is in IDLE.
REQ-008 abort  input  1  synchronous abort; returns the block to IDLE.
REQ-009 psum_valid  input  1  a 128-bit psum word is present on the array side.
REQ-010 psum_ready  output  1  the block accepts a psum word this cycle.
REQ-011 sfu_inst  output  4  SFU command: bit0 = write, bit1 = accumulate, bit2 = read.
REQ-012 sfu_nij  output  11  SFU read address (nij).
REQ-013 sfu_oc  output  11  SFU output-channel lane select.
REQ-014 out_valid  output  1  the SFU out port holds the result for out_nij / out_oc.
REQ-015 out_nij  output  11  nij tag aligned with out_valid.
REQ-016 out_oc  output  11  oc tag aligned with out_valid.
REQ-017 busy  output  1  high whenever the state is not IDLE.
REQ-018 done  output  1  one-cycle pulse when a tile completes.

Function
REQ-019 The block SHALL use the states IDLE, WRITE, ACC, READ, DRAIN.
REQ-020 IDLE SHALL go to WRITE on start, clearing the write counter wcnt.
REQ-021 In WRITE, psum_ready SHALL be 1, and sfu_inst[0] SHALL equal psum_valid & psum_ready, combinationally.
- wcnt increments on each accepted word.
- After word number LEN_KIJ*LEN_NIJ is accepted, the state goes to ACC.
REQ-022 On entering ACC, the block SHALL drive sfu_inst[1] for exactly one cycle, then hold sfu_inst at 0.
- It waits (LEN_KIJ+1)*LEN_NIJ cycles (160 at defaults), then goes to READ.
REQ-023 In READ, the block SHALL drive sfu_inst[2] = 1 every cycle.
- sfu_nij / sfu_oc step oc-fastest, 0..NUM_OC-1 within nij, then nij 0..LEN_NIJ-1: exactly LEN_NIJ*NUM_OC issues.
- After the last issue, the state goes to DRAIN.
REQ-024 out_valid, out_nij and out_oc SHALL be the read-issue flag and indices delayed by exactly RD_LAT cycles.
REQ-025 DRAIN SHALL last RD_LAT cycles, then pulse done for one cycle and return to IDLE.
REQ-026 psum_ready SHALL be 0 in every state except WRITE; sfu_inst SHALL never have more than one bit set.
REQ-027 start while busy SHALL be ignored, with no effect on the counters or outputs.
REQ-028 abort SHALL take priority over every transition.
- Next cycle: state IDLE, counters cleared, sfu_inst = 0, the delay pipe flushed, out_valid = 0, done not pulsed.
REQ-029 When start and abort are asserted in the same IDLE cycle, abort SHALL win and the block SHALL stay in IDLE.
REQ-030 All counters SHALL be 11 bits wide, and terminal compares SHALL use LEN-1 values (no wrap past the terminal count).

Reset
REQ-031 reset SHALL force, asynchronously:
- state = IDLE;
- all counters = 0;
- psum_ready, sfu_inst, out_valid, busy, done = 0;
- sfu_nij, sfu_oc, out_nij, out_oc = 0.
REQ-032 Reset mid-tile SHALL discard all progress; the next start begins a fresh tile.

Structure
REQ-033 The state encoding and the sfu_inst bit-position constants (WR = 0, ACC = 1, RD = 2) SHALL live in a shared package, sfu_pkg.
REQ-034 The RD_LAT tag/valid delay SHALL be a sub-module, tag_delay, parameterised on width and depth.

Verification
REQ-035 Defaults, start, psum_valid held high: 144 write cycles with sfu_inst = 4'b0001, then one 4'b0010, then 160 idle cycles, then 128 reads with 4'b0100; done arrives RD_LAT cycles after the last read.
REQ-036 psum_valid toggled randomly at 50%: exactly 144 write pulses issued; ACC entered only after the 144th.
REQ-037 Read phase: the first issue has nij = 0, oc = 0; issue 9 has nij = 1, oc = 1; out_valid with the same tags appears 2 cycles after each issue.
REQ-038 start re-pulsed during ACC: no state change; done still arrives once, on schedule.
REQ-039 abort at write 70: IDLE next cycle, psum_ready = 0, no done; a following start accepts 144 fresh writes.
REQ-040 reset asserted mid-READ: all outputs 0 immediately, with no clock edge required; out_valid stays 0 after release.
